ringosc_freq_meter: RTL
=======================

RINGOSC_FREQ_METER -- requirements
Module: ringosc_freq_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the edge counter and of the result.
REQ-002 Port clk  in  1: sole clock; all state updates on its rising edge.
REQ-003 Port rst  in  1: reset, synchronous and active-high.
REQ-004 Port osc_in  in  1: ring-oscillator-derived tap (osc or a counter stage), asynchronous to clk.
REQ-005 Port start  in  1: one-cycle request to begin a measurement.
REQ-006 Port win_sel  in  4: window-length select, sampled when start is accepted.
REQ-007 Port byte_sel  in  2: selects the result byte driven on byte_out.
REQ-008 Port busy  out  1: high while a measurement window is open.
REQ-009 Port done  out  1: one-cycle pulse when the result updates.
REQ-010 Port result  out  CNT_W: last completed edge count.
REQ-011 Port overflow  out  1: last completed count saturated.
REQ-012 Port byte_out  out  8: combinational view of result >> (8*byte_sel); bits above CNT_W-1 read as zero.

Function
REQ-013 osc_in SHALL pass a 2-flop synchronizer and then a rising-edge detector, giving edge_pulse 3 clk cycles after the synchronizer input samples high.
REQ-014 The FSM SHALL have states IDLE, MEASURE and DONE.
REQ-015 IDLE -> MEASURE when start=1; win_sel is latched and the window counter loads N = 2^(win_sel+4) (16 to 524288 cycles).
REQ-016 MEASURE SHALL last exactly N cycles; each cycle with edge_pulse=1 increments the edge count by 1.
REQ-017 The edge count SHALL clear to 0 on entry to MEASURE.
REQ-018 The edge count SHALL saturate at 2^CNT_W-1; an increment attempted at saturation sets an internal overflow flag.
REQ-019 After the last MEASURE cycle the FSM SHALL enter DONE for exactly one cycle.
REQ-020 In DONE: result <= edge count, overflow <= overflow flag, and done=1.
REQ-021 DONE -> IDLE unconditionally, except as stated in REQ-029.
REQ-022 start SHALL be ignored in MEASURE and DONE; no queuing.
REQ-023 busy = (state == MEASURE).
REQ-024 result and overflow SHALL hold their values between DONE cycles.
REQ-025 Changing win_sel during MEASURE SHALL not affect the running window.

Reset
REQ-026 With rst=1 at a clk edge: state=IDLE, synchronizer and edge flops=0, edge count=0, window counter=0, result=0, overflow=0, done=0, busy=0.
REQ-027 Reset asserted mid-MEASURE SHALL abort the window, discard the partial count, and pulse no done.
REQ-028 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-029 With macro RINGOSC_FREQ_METER_CONT_EN defined: DONE -> MEASURE (continuous mode) with the latched window reused, and start is only honoured from IDLE after reset; without it, DONE -> IDLE and each measurement needs a fresh start.

Structure
REQ-030 Package ringosc_pkg SHALL hold the FSM state enum (IDLE, MEASURE, DONE) and constant WIN_BASE_LOG2 = 4.
REQ-031 Sub-module ringosc_edge_sync SHALL hold the 2-flop synchronizer and the rising-edge detector, with ports clk, rst, async_in and edge_pulse.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Basic count: osc_in toggles every 4 clk (period 8), win_sel=0, start -> done after 16+1 cycles, result=2, overflow=0.
- Long window: period 8, win_sel=4 (N=256) -> result=32, with ±1 tolerance for phase only.
- Saturation: CNT_W=16, osc_in toggling every clk, win_sel=15 -> result=0xFFFF, overflow=1; byte_sel=1 -> byte_out=0xFF; byte_sel=2 -> byte_out=0x00.
- start ignored: a start pulse mid-MEASURE -> exactly one done, and busy stays continuously high across the window.
- Reset abort: rst for 1 cycle at window cycle 10 -> busy=0 the next cycle, result=0, no done pulse.
- Continuous mode (with RINGOSC_FREQ_METER_CONT_EN): a single start -> done pulses every N+1 cycles, and busy is low only in the DONE cycles.

Source files
------------

// File: rtl/ringosc_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ringosc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int WIN_BASE_LOG2 = 4;
  localparam int WIN_W         = 20;

  typedef logic [WIN_W-1:0] win_t;

  // Window length in clk cycles: 2^(sel + WIN_BASE_LOG2), 16 .. 524288.
  function automatic win_t win_cycles(input logic [3:0] sel);
    return win_t'(1) << (32'(sel) + WIN_BASE_LOG2);
  endfunction

endpackage

// File: rtl/ringosc_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for an
// input that is asynchronous to clk.
module ringosc_edge_sync
  import ringosc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_meta  <= async_in;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_pulse <= r_sync & ~r_prev;
    end
  end

  assign edge_pulse = r_pulse;

endmodule

// File: rtl/ringosc_freq_meter.sv
// Counts ring-oscillator rising edges over a 2^(win_sel+4)-cycle window.
// Define RINGOSC_FREQ_METER_CONT_EN for back-to-back continuous windows.
module ringosc_freq_meter
  import ringosc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic [3:0]       win_sel,
  input  logic [1:0]       byte_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic [7:0]       byte_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  win_t             r_win;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;
  logic [CNT_W-1:0] r_result;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;
`ifdef RINGOSC_FREQ_METER_CONT_EN
  logic [3:0]       r_wsel;
`endif

  logic             w_edge;
  logic             w_at_max;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_flag_next;
  logic [31:0]      w_ext;

  ringosc_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (osc_in),
    .edge_pulse (w_edge)
  );

  // Saturating edge count; an edge seen at full scale latches the flag.
  assign w_at_max    = (r_cnt == CNT_MAX);
  assign w_cnt_next  = (w_edge && !w_at_max) ? r_cnt + 1'b1 : r_cnt;
  assign w_flag_next = r_flag | (w_edge & w_at_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_win    <= '0;
      r_cnt    <= '0;
      r_flag   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef RINGOSC_FREQ_METER_CONT_EN
      r_wsel   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= MEASURE;
            r_busy  <= 1'b1;
            r_win   <= win_cycles(win_sel);
            r_cnt   <= '0;
            r_flag  <= 1'b0;
`ifdef RINGOSC_FREQ_METER_CONT_EN
            r_wsel  <= win_sel;
`endif
          end
        end
        MEASURE: begin
          r_cnt  <= w_cnt_next;
          r_flag <= w_flag_next;
          if (r_win == win_t'(1)) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_cnt_next;
            r_ovf    <= w_flag_next;
          end else begin
            r_win <= r_win - win_t'(1);
          end
        end
        DONE: begin
`ifdef RINGOSC_FREQ_METER_CONT_EN
          r_state <= MEASURE;
          r_busy  <= 1'b1;
          r_win   <= win_cycles(r_wsel);
          r_cnt   <= '0;
          r_flag  <= 1'b0;
`else
          r_state <= IDLE;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_ovf;

  // Only four bytes are addressable, so a 32-bit zero-extended view suffices.
  assign w_ext = 32'(r_result);

  always_comb begin
    byte_out = 8'd0;
    case (byte_sel)
      2'd0:    byte_out = w_ext[7:0];
      2'd1:    byte_out = w_ext[15:8];
      2'd2:    byte_out = w_ext[23:16];
      default: byte_out = w_ext[31:24];
    endcase
  end

endmodule
